// File: rtl/reg_file.sv
// MIPS general-purpose register file: 2^ADDR_W x DATA_W, two combinational read
// ports, one synchronous write port, entry 0 hardwired to zero.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wadd,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              we_eff;

    assign we_eff = wen && (wadd != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we_eff) begin
            regs[wadd] <= wdata;
        end
    end

    // Address 0 is forced to zero on read; no write-to-read bypass.
    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: stimulus pushes expected read data into a queue,
// a monitor process pops and compares whenever a sample is presented.
module tb_reg_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              wen;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [ADDR_W-1:0] wadd;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .ra1   (ra1),
        .ra2   (ra2),
        .wadd  (wadd),
        .wdata (wdata),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    typedef struct {
        string             name;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Monitor: compares the presented read data against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (rd1 !== e.e1 || rd2 !== e.e2) begin
                    errors++;
                    $display("FAIL %s: rd1=%h rd2=%h required rd1=%h rd2=%h",
                             e.name, rd1, rd2, e.e1, e.e2);
                end
            end
        end
    end

    task automatic expect_rd(input string name, input logic [DATA_W-1:0] e1,
                             input logic [DATA_W-1:0] e2);
        exp_t e;
        e.name = name;
        e.e1   = e1;
        e.e2   = e2;
        q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    task automatic after_neg();
        @(negedge clk);
        #2;
    endtask

    task automatic after_pos();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset held with a write pending to r1
        rst = 1'b0; wen = 1'b1; wadd = 5'd1; wdata = 32'd4; ra1 = 5'd1; ra2 = 5'd0;
        #3;
        expect_rd("reset_initial", 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            after_pos();
            expect_rd("reset_after_edge", 32'd0, 32'd0);
        end

        // Release between edges: r1 still 0 until the next edge writes it
        after_neg();
        rst = 1'b1; ra2 = 5'd2;
        #1;
        expect_rd("release_before_edge", 32'd0, 32'd0);
        after_pos();
        expect_rd("basic_write", 32'd4, 32'd0);

        // Write to r0 is discarded
        after_neg();
        wen = 1'b1; wadd = 5'd0; wdata = 32'd1; ra1 = 5'd1; ra2 = 5'd0;
        after_pos();
        expect_rd("r0_protect", 32'd4, 32'd0);

        // Top register, read-during-write shows old value before the edge
        after_neg();
        wen = 1'b1; wadd = 5'd31; wdata = 32'd7; ra1 = 5'd31; ra2 = 5'd1;
        #1;
        expect_rd("top_before_edge", 32'd0, 32'd4);
        after_pos();
        expect_rd("top_reg", 32'd7, 32'd4);

        // Write disable
        after_neg();
        wen = 1'b0; wadd = 5'd1; wdata = 32'd3; ra1 = 5'd1; ra2 = 5'd0;
        repeat (3) after_pos();
        expect_rd("wen_low", 32'd4, 32'd0);
        after_neg();
        wdata = 32'd0; ra2 = 5'd2;
        after_pos();
        expect_rd("wen_low_ra2", 32'd4, 32'd0);

        // Same-address read on both ports, full-width data
        after_neg();
        wen = 1'b1; wadd = 5'd5; wdata = 32'hDEAD_BEEF; ra1 = 5'd5; ra2 = 5'd5;
        #1;
        expect_rd("rdw_old", 32'd0, 32'd0);
        after_pos();
        expect_rd("rdw_new", 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Back-to-back writes, last wins
        after_neg();
        wdata = 32'hA5A5_0001;
        after_pos();
        expect_rd("b2b_first", 32'hA5A5_0001, 32'hA5A5_0001);
        after_neg();
        wdata = 32'hFFFF_FFFF;
        after_pos();
        expect_rd("b2b_last", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Other registers unaffected by the r5 writes
        after_neg();
        wen = 1'b0; ra1 = 5'd1; ra2 = 5'd31;
        #1;
        expect_rd("pre_reset_hold", 32'd4, 32'd7);

        // Mid-cycle reset pulse clears immediately
        #4;
        rst = 1'b0;
        #1;
        expect_rd("async_clear", 32'd0, 32'd0);
        ra1 = 5'd5;
        #1;
        expect_rd("async_clear_r5", 32'd0, 32'd0);

        // Write edge during reset: reset wins
        wen = 1'b1; wadd = 5'd1; wdata = 32'd9; ra1 = 5'd1;
        after_pos();
        expect_rd("reset_wins", 32'd0, 32'd0);
        after_neg();
        rst = 1'b1; wen = 1'b0;
        after_pos();
        expect_rd("post_reset_idle", 32'd0, 32'd0);

        // Write works again after release
        after_neg();
        wen = 1'b1; wadd = 5'd31; wdata = 32'h1234_5678;
        after_pos();
        expect_rd("post_reset_write", 32'd0, 32'h1234_5678);

        for (int i = 0; i < 10 && q.size() > 0; i++) #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left in queue, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
